// File: rtl/vlsu_cam_age_match.sv
// Multi-port tag CAM for the vector LSU: WRITE write ports, READ age-ordered search ports.
// Define CAM_WR_BYPASS_EN to forward same-edge writes into searches.
module vlsu_cam_age_match #(
    parameter  int unsigned WIDTH   = 50,
    parameter  int unsigned DEPTH   = 32,
    parameter  int unsigned WRITE   = 1,
    parameter  int unsigned READ    = 3,
    localparam int unsigned ADDRESS = $clog2(DEPTH)
) (
    input  logic                           clk,
    input  logic                           arst_n,
    input  logic                           flush_i,
    input  logic [ADDRESS-1:0]             head_i,
    input  logic [WRITE-1:0]               write_i,
    input  logic [WRITE-1:0][ADDRESS-1:0]  write_addr_i,
    input  logic [WRITE-1:0][WIDTH-1:0]    write_data_i,
    input  logic                           clear_i,
    input  logic [ADDRESS-1:0]             clear_addr_i,
    input  logic [READ-1:0]                read_i,
    input  logic [READ-1:0][WIDTH-1:0]     read_data_i,
    input  logic [READ-1:0][DEPTH-1:0]     enable_i,
    output logic [READ-1:0]                match_o,
    output logic [READ-1:0][ADDRESS-1:0]   match_addr_o,
    output logic [READ-1:0]                multi_o
);

    logic [WIDTH-1:0]              tag_q [DEPTH];
    logic [WIDTH-1:0]              tag_d [DEPTH];
    logic [DEPTH-1:0]              valid_q, valid_d;

    logic [WIDTH-1:0]              view_tag [DEPTH];
    logic [DEPTH-1:0]              view_valid;
    logic [READ-1:0][DEPTH-1:0]    hit;

    logic [READ-1:0]               found, several;
    logic [READ-1:0][ADDRESS-1:0]  sel;

    logic [READ-1:0]               match_q, match_d;
    logic [READ-1:0]               multi_q, multi_d;
    logic [READ-1:0][ADDRESS-1:0]  addr_q, addr_d;

    // Clear first, then writes in ascending port order: a write beats a clear on the same
    // entry and the highest port wins among writes. Flush dominates everything.
    always_comb begin
        tag_d   = tag_q;
        valid_d = valid_q;
        if (clear_i) begin
            valid_d[clear_addr_i] = 1'b0;
        end
        for (int unsigned p = 0; p < WRITE; p++) begin
            if (write_i[p] && !flush_i) begin
                tag_d[write_addr_i[p]]   = write_data_i[p];
                valid_d[write_addr_i[p]] = 1'b1;
            end
        end
        if (flush_i) begin
            valid_d = '0;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag storage carries no reset; only the valid bits qualify it.
    always_ff @(posedge clk) begin
        tag_q <= tag_d;
    end

`ifdef CAM_WR_BYPASS_EN
    // Same-edge writes are visible to searches; clear and flush are not forwarded.
    always_comb begin
        view_tag   = tag_q;
        view_valid = valid_q;
        for (int unsigned p = 0; p < WRITE; p++) begin
            if (write_i[p]) begin
                view_tag[write_addr_i[p]]   = write_data_i[p];
                view_valid[write_addr_i[p]] = 1'b1;
            end
        end
    end
`else
    always_comb begin
        view_tag   = tag_q;
        view_valid = valid_q;
    end
`endif

    always_comb begin
        hit = '0;
        for (int unsigned r = 0; r < READ; r++) begin
            for (int unsigned e = 0; e < DEPTH; e++) begin
                hit[r][e] = view_valid[e] & enable_i[r][e] & (view_tag[e] == read_data_i[r]);
            end
        end
    end

    // Walk entries in age order from head; the first hit is the oldest, any later one
    // means more than one entry matched.
    always_comb begin
        logic [ADDRESS-1:0] idx;
        found   = '0;
        several = '0;
        sel     = '0;
        idx     = '0;
        for (int unsigned r = 0; r < READ; r++) begin
            for (int unsigned d = 0; d < DEPTH; d++) begin
                idx = head_i + ADDRESS'(d);
                if (hit[r][idx]) begin
                    if (found[r]) begin
                        several[r] = 1'b1;
                    end else begin
                        found[r] = 1'b1;
                        sel[r]   = idx;
                    end
                end
            end
        end
    end

    always_comb begin
        match_d = '0;
        multi_d = '0;
        addr_d  = addr_q;
        for (int unsigned r = 0; r < READ; r++) begin
            if (read_i[r]) begin
                match_d[r] = found[r];
                multi_d[r] = several[r];
                addr_d[r]  = found[r] ? sel[r] : '0;
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            match_q <= '0;
            multi_q <= '0;
            addr_q  <= '0;
        end else begin
            match_q <= match_d;
            multi_q <= multi_d;
            addr_q  <= addr_d;
        end
    end

    assign match_o      = match_q;
    assign multi_o      = multi_q;
    assign match_addr_o = addr_q;

endmodule
